ifetch_unit: RTL and testbench
==============================

IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 Parameter DEPTH, default 4: instruction queue entries, power of two, 2..16.
REQ-002 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 mem_req  output  1  instruction-memory read request.
REQ-006 mem_addr  output  32  word-aligned fetch address, valid while mem_req=1.
REQ-007 mem_ack  input  1  memory returns mem_rdata for the current request this cycle.
REQ-008 mem_rdata  input  32  instruction word, sampled only when mem_req=1 and mem_ack=1.
REQ-009 redirect  input  1  flush and restart fetch; driven by the datapath's jump/taken-branch.
REQ-010 redirect_pc  input  32  new fetch address; bits [1:0] ignored and forced to 00.
REQ-011 inst_valid  output  1  queue head holds a valid instruction.
REQ-012 inst_ready  input  1  datapath consumes the head this cycle.
REQ-013 inst_data  output  32  head instruction word; 0 when inst_valid=0.
REQ-014 inst_pc  output  32  address of inst_data; 0 when inst_valid=0.

Function
REQ-015 The FSM SHALL have states IDLE, WAIT, DISCARD; at most one memory request is outstanding.
REQ-016 IDLE->WAIT when free queue slots >0 after this cycle's pop; mem_req=1 and mem_addr=fetch_pc are registered.
REQ-017 In WAIT, mem_req and mem_addr SHALL stay constant until mem_ack=1.
REQ-018 On ack in WAIT without redirect: push {fetch_pc, mem_rdata}, fetch_pc+=4, and go to WAIT (next request, back-to-back) if a slot remains after this push, else IDLE.
REQ-019 fetch_pc SHALL wrap 32'hFFFF_FFFC -> 32'h0000_0000 without error.
REQ-020 Push-to-output latency: instruction acked at edge N is inst_valid after edge N.
REQ-021 Pop occurs on inst_valid=1 and inst_ready=1; simultaneous push and pop SHALL be legal at any occupancy.
REQ-022 redirect=1 SHALL empty the queue at the next edge (inst_valid=0 the following cycle) and set fetch_pc to {redirect_pc[31:2],2'b00}.
REQ-023 A pop in the same cycle as redirect SHALL count as consumed; no other queued entry survives.
REQ-024 redirect in WAIT without mem_ack: go to DISCARD, holding the old mem_req/mem_addr until ack; the acked data SHALL be dropped, then request the redirect address.
REQ-025 redirect with mem_ack in the same cycle: the returning data SHALL be dropped and the next request SHALL use the redirect address.
REQ-026 redirect in DISCARD SHALL update fetch_pc only; last redirect wins.
REQ-027 Queue entries SHALL never be lost or duplicated; inst_valid=1 with inst_ready=0 holds inst_data/inst_pc stable.

Reset
REQ-028 While reset=0: state IDLE, queue empty, mem_req=0, mem_addr=RESET_PC, inst_valid=0, inst_data=0, inst_pc=0, fetch_pc=RESET_PC.
REQ-029 mem_req SHALL assert after the first rising edge following reset release.
REQ-030 Reset asserted mid-request SHALL abort it immediately; a late mem_ack is ignored.

Configuration
REQ-031 Macro IFETCH_PERF_CNT_EN, when defined, adds output fetch_count (32) counting accepted pops and output flush_count (16) counting redirects, both saturating, reset to 0.
REQ-032 Without IFETCH_PERF_CNT_EN these ports and counters SHALL not exist; all other behaviour is identical.

Structure
REQ-033 Package ifetch_pkg SHALL hold the FSM state enum, the 32-bit instruction/address width constants and the {pc, inst} entry struct.
REQ-034 Queue storage and pointers SHALL be a sub-module fetch_fifo (push, pop, flush, full, empty, count).

Verification
REQ-035 Reset release, mem_ack always 1, inst_ready=1 -> addresses 0,4,8,... issued back-to-back; inst_pc tracks one cycle behind.
REQ-036 inst_ready=0 for 10 cycles, mem_ack=1 -> exactly DEPTH (4) fetches, then mem_req=0 until a pop.
REQ-037 redirect_pc=32'h0000_0043 while WAIT with mem_ack=0 for 3 cycles -> old address held, its data dropped, next mem_addr=32'h0000_0040.
REQ-038 redirect and mem_ack in the same cycle with the queue holding 2 entries -> queue empty next cycle; first new entry has inst_pc=redirect address.
REQ-039 redirect_pc=32'hFFFF_FFF8 -> fetched inst_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-040 reset=0 asserted in WAIT, mem_ack=1 one cycle after release -> no push; mem_addr=RESET_PC re-requested.

Source files
------------

// File: rtl/ifetch_pkg.sv
// rtl/ifetch_pkg.sv - shared widths, FSM states and queue entry type for the instruction fetch unit
package ifetch_pkg;

   localparam int INST_W = 32;
   localparam int ADDR_W = 32;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT    = 2'd1,
      DISCARD = 2'd2
   } fetchState_t;

   typedef struct packed {
      logic [ADDR_W-1:0] pc;
      logic [INST_W-1:0] inst;
   } fetchEntry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - instruction queue storage and pointers; flush empties it at the next edge
module fetch_fifo
   import ifetch_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int PW = $clog2(DEPTH),
   localparam int CW = PW + 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        push,
   input  fetchEntry_t pushData,
   input  logic        pop,
   input  logic        flush,
   output fetchEntry_t headData,
   output logic        full,
   output logic        empty,
   output logic [CW-1:0] count
);

   fetchEntry_t   mem [DEPTH];
   logic [PW-1:0] wrPtr;
   logic [PW-1:0] rdPtr;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wrPtr <= '0;
         rdPtr <= '0;
         cnt   <= '0;
      end else if (flush) begin
         wrPtr <= '0;
         rdPtr <= '0;
         cnt   <= '0;
      end else begin
         if (push) wrPtr <= wrPtr + 1'b1;
         if (pop)  rdPtr <= rdPtr + 1'b1;
         cnt <= cnt + CW'(push) - CW'(pop);
      end
   end

   // Storage needs no reset: the head is masked by empty at the top level.
   always_ff @(posedge clk) begin
      if (push && !flush) mem[wrPtr] <= pushData;
   end

   assign headData = mem[rdPtr];
   assign full     = (cnt == CW'(DEPTH));
   assign empty    = (cnt == '0);
   assign count    = cnt;

endmodule

// File: rtl/ifetch_unit.sv
// rtl/ifetch_unit.sv - single-outstanding instruction fetcher feeding a small queue
// Define IFETCH_PERF_CNT_EN to add saturating fetch_count/flush_count outputs.
module ifetch_unit
   import ifetch_pkg::*;
#(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst_data,
   output logic [31:0] inst_pc
`ifdef IFETCH_PERF_CNT_EN
   ,
   output logic [31:0] fetch_count,
   output logic [15:0] flush_count
`endif
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] LAST_FREE = CW'(DEPTH - 1);

   fetchState_t       state;
   fetchState_t       stateNext;
   logic [ADDR_W-1:0] fetchPc;
   logic [ADDR_W-1:0] fetchPcNext;
   logic [ADDR_W-1:0] memAddrNext;
   logic [ADDR_W-1:0] redirectAddr;
   logic              push;
   logic              pop;
   logic              full;
   logic              empty;
   logic [CW-1:0]     count;
   fetchEntry_t       pushEntry;
   fetchEntry_t       head;

   assign redirectAddr = redirect_pc & ~32'h3;
   assign pop          = !empty && inst_ready;
   assign pushEntry    = {fetchPc, mem_rdata};
   assign mem_req      = (state != IDLE);
   assign inst_valid   = !empty;
   assign inst_data    = empty ? '0 : head.inst;
   assign inst_pc      = empty ? '0 : head.pc;

   fetch_fifo #(.DEPTH(DEPTH)) uFifo (
      .clk      (clk),
      .reset    (reset),
      .push     (push),
      .pushData (pushEntry),
      .pop      (pop),
      .flush    (redirect),
      .headData (head),
      .full     (full),
      .empty    (empty),
      .count    (count)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         fetchPc  <= RESET_PC;
         mem_addr <= RESET_PC;
      end else begin
         state    <= stateNext;
         fetchPc  <= fetchPcNext;
         mem_addr <= memAddrNext;
      end
   end

   always_comb begin
      stateNext   = state;
      fetchPcNext = fetchPc;
      memAddrNext = mem_addr;
      push        = 1'b0;
      case (state)
         IDLE: begin
            if (redirect) begin
               fetchPcNext = redirectAddr;
               memAddrNext = redirectAddr;
               stateNext   = WAIT;
            end else if (!full || pop) begin
               memAddrNext = fetchPc;
               stateNext   = WAIT;
            end
         end
         WAIT: begin
            if (redirect) begin
               fetchPcNext = redirectAddr;
               if (mem_ack) memAddrNext = redirectAddr;
               else         stateNext   = DISCARD;
            end else if (mem_ack) begin
               push        = 1'b1;
               fetchPcNext = fetchPc + 32'd4;
               // A request is only issued with a free slot, so a same-cycle pop always leaves one.
               if (pop || count < LAST_FREE) memAddrNext = fetchPc + 32'd4;
               else                          stateNext   = IDLE;
            end
         end
         DISCARD: begin
            if (redirect) fetchPcNext = redirectAddr;
            if (mem_ack) begin
               stateNext   = WAIT;
               memAddrNext = redirect ? redirectAddr : fetchPc;
            end
         end
         default: stateNext = IDLE;
      endcase
   end

`ifdef IFETCH_PERF_CNT_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fetch_count <= '0;
         flush_count <= '0;
      end else begin
         if (pop && fetch_count != '1)      fetch_count <= fetch_count + 32'd1;
         if (redirect && flush_count != '1) flush_count <= flush_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// tb/tb_ifetch_unit.sv - scoreboard bench for ifetch_unit with a behavioural instruction memory
module tb_ifetch_unit;

   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst_data;
   logic [31:0] inst_pc;
`ifdef IFETCH_PERF_CNT_EN
   logic [31:0] fetch_count;
   logic [15:0] flush_count;
`endif

   always #5 clk = ~clk;

   ifetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk         (clk),
      .reset       (reset),
      .mem_req     (mem_req),
      .mem_addr    (mem_addr),
      .mem_ack     (mem_ack),
      .mem_rdata   (mem_rdata),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .inst_valid  (inst_valid),
      .inst_ready  (inst_ready),
      .inst_data   (inst_data),
      .inst_pc     (inst_pc)
`ifdef IFETCH_PERF_CNT_EN
      ,
      .fetch_count (fetch_count),
      .flush_count (flush_count)
`endif
   );

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } expEntry_t;

   expEntry_t   sb[$];
   int          checks = 0;
   int          failures = 0;
   int          pushCount = 0;
   int          popCount = 0;
   int          redirCount = 0;
   logic [31:0] expPc;
   logic        discard;
   logic        prevReq;
   logic        prevAck;
   logic [31:0] prevAddr;

   function automatic logic [31:0] memWord(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // One cycle: check outputs, drive inputs, and predict what the coming edge does.
   task automatic step(input logic ack, input logic rdy, input logic redir, input logic [31:0] rpc);
      expEntry_t e;
      @(negedge clk);
      checkEq("valid_vs_queue", 32'(inst_valid), 32'(sb.size() != 0));
      if (!inst_valid) begin
         checkEq("idle_data", inst_data, 32'h0);
         checkEq("idle_pc", inst_pc, 32'h0);
      end
      if (prevReq && !prevAck) begin
         checkEq("req_held", 32'(mem_req), 32'h1);
         checkEq("addr_held", mem_addr, prevAddr);
      end
      mem_ack     = ack;
      mem_rdata   = mem_req ? memWord(mem_addr) : 32'hDEAD_BEEF;
      inst_ready  = rdy;
      redirect    = redir;
      redirect_pc = rpc;
      if (inst_valid && rdy) begin
         popCount++;
         if (sb.size() != 0) begin
            e = sb.pop_front();
            checkEq("pop_pc", inst_pc, e.pc);
            checkEq("pop_data", inst_data, e.inst);
         end
      end
      if (redir) begin
         sb.delete();
         expPc = rpc & ~32'h3;
         discard = mem_req && !ack;
         redirCount++;
      end else if (mem_req && ack) begin
         if (discard) begin
            discard = 1'b0;
         end else begin
            checkEq("fetch_addr", mem_addr, expPc);
            sb.push_back('{pc: expPc, inst: memWord(expPc)});
            expPc += 32'd4;
            pushCount++;
         end
      end
      prevReq  = mem_req;
      prevAck  = ack;
      prevAddr = mem_addr;
   endtask

   task automatic doReset();
      @(negedge clk);
      reset       = 1'b0;
      mem_ack     = 1'b0;
      inst_ready  = 1'b0;
      redirect    = 1'b0;
      redirect_pc = 32'h0;
      #1;
      checkEq("rst_req", 32'(mem_req), 32'h0);
      checkEq("rst_addr", mem_addr, RESET_PC);
      checkEq("rst_valid", 32'(inst_valid), 32'h0);
      checkEq("rst_data", inst_data, 32'h0);
      checkEq("rst_pc", inst_pc, 32'h0);
      @(negedge clk);
      reset   = 1'b1;
      mem_ack = 1'b1;
      sb.delete();
      expPc      = RESET_PC;
      discard    = 1'b0;
      prevReq    = 1'b0;
      prevAck    = 1'b0;
      popCount   = 0;
      redirCount = 0;
      @(posedge clk);
      #1;
      checkEq("first_req", 32'(mem_req), 32'h1);
      checkEq("first_addr", mem_addr, RESET_PC);
      checkEq("late_ack_no_push", 32'(inst_valid), 32'h0);
   endtask

   initial begin
      int base;
      reset       = 1'b1;
      mem_ack     = 1'b0;
      mem_rdata   = 32'h0;
      redirect    = 1'b0;
      redirect_pc = 32'h0;
      inst_ready  = 1'b0;
      doReset();

      // Streaming: back-to-back requests 0,4,8,...
      for (int i = 0; i < 12; i++) begin
         step(1'b1, 1'b1, 1'b0, 32'h0);
         checkEq("stream_req", 32'(mem_req), 32'h1);
      end

      // Stalled consumer: exactly DEPTH fetches, then requests stop.
      doReset();
      base = pushCount;
      for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
      checkEq("full_fetches", 32'(pushCount - base), 32'(DEPTH));
      checkEq("full_no_req", 32'(mem_req), 32'h0);
      step(1'b1, 1'b1, 1'b0, 32'h0);
      step(1'b0, 1'b1, 1'b0, 32'h0);
      checkEq("refill_req", 32'(mem_req), 32'h1);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 32'h0);

      // Redirect while waiting: old address held, its data dropped, then 0x40.
      step(1'b0, 1'b1, 1'b1, 32'h0000_0043);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 32'h0);
      step(1'b1, 1'b1, 1'b0, 32'h0);
      @(posedge clk);
      #1;
      checkEq("redir_addr", mem_addr, 32'h0000_0040);
      checkEq("redir_req", 32'(mem_req), 32'h1);

      // Redirect together with ack while two entries are queued.
      step(1'b1, 1'b0, 1'b0, 32'h0);
      step(1'b1, 1'b0, 1'b0, 32'h0);
      step(1'b1, 1'b0, 1'b1, 32'h0000_0100);
      @(posedge clk);
      #1;
      checkEq("flush_empty", 32'(inst_valid), 32'h0);
      for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 32'h0);

      // Redirect with a same-cycle pop, then fetch across the address wrap.
      step(1'b0, 1'b1, 1'b1, 32'hFFFF_FFF8);
      for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 32'h0);

      // Reset in the middle of an outstanding request.
      step(1'b0, 1'b1, 1'b0, 32'h0);
      doReset();
      for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 32'h0);

      for (int i = 0; i < 300; i++) begin
         step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) < 7),
              1'($urandom_range(0, 19) == 0), $urandom);
      end
      for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 32'h0);

`ifdef IFETCH_PERF_CNT_EN
      @(posedge clk);
      #1;
      checkEq("perf_fetch", fetch_count, 32'(popCount));
      checkEq("perf_flush", 32'(flush_count), 32'(redirCount));
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
